// File: rtl/ldpc_3gpp_enc_reg_ctrl_pkg.sv
// Shared types for the LDPC encoder matrix-register controller.
// dat_t is the word carried on the source, register and sink streams.
package ldpc_3gpp_enc_reg_ctrl_pkg;

  localparam int unsigned DAT_W = 8;

  typedef logic [DAT_W-1:0] dat_t;

endpackage

// File: rtl/ldpc_3gpp_enc_reg_ctrl.sv
// Burst controller for the LDPC encoder matrix register: streams source words into the
// register (WRITE) or issues back-to-back reads and forwards the returned words (READ).
module ldpc_3gpp_enc_reg_ctrl
  import ldpc_3gpp_enc_reg_ctrl_pkg::*;
#(
  parameter int unsigned pADDR_W = 8,
  parameter int unsigned pPIPE   = 0
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  logic               iop,
  input  logic [pADDR_W-1:0] ilen,
  input  logic               isval,
  input  dat_t               isdat,
  output logic               oreg_write,
  output logic               oreg_wstart,
  output dat_t               oreg_wdat,
  output logic               oreg_read,
  output logic               oreg_rstart,
  input  logic               ireg_val,
  input  logic               ireg_start,
  input  dat_t               ireg_dat,
  output logic               oval,
  output logic               osop,
  output logic               oeop,
  output dat_t               odat,
  output logic               obusy,
  output logic               odone
);

  localparam int unsigned CNT_W = pADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Register latency (3+pPIPE) is absorbed by the return counter, so pPIPE only bounds it.
  if (pPIPE > 15) begin : g_pipe_out_of_range
  end

  state_t             state_q, state_d;
  logic [pADDR_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]   iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic [CNT_W-1:0]   words;

  logic wr_q, wr_d, wstart_q, wstart_d;
  logic rd_q, rd_d, rstart_q, rstart_d;
  logic val_q, val_d, sop_q, sop_d, eop_q, eop_d;
  logic busy_q, busy_d, done_q, done_d;
  dat_t wdat_q, wdat_d, dat_q, dat_d;

  assign words = CNT_W'(len_q) + CNT_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    iss_cnt_d = iss_cnt_q;
    ret_cnt_d = ret_cnt_q;
    wr_d      = 1'b0;
    wstart_d  = 1'b0;
    wdat_d    = wdat_q;
    rd_d      = 1'b0;
    rstart_d  = 1'b0;
    val_d     = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    dat_d     = dat_q;
    done_d    = 1'b0;

    // Returned words are only meaningful while a read burst is outstanding.
    if (ireg_val && (state_q == ST_READ || state_q == ST_DRAIN)) begin
      val_d     = 1'b1;
      sop_d     = ireg_start;
      dat_d     = ireg_dat;
      eop_d     = (ret_cnt_q + CNT_W'(1)) == words;
      ret_cnt_d = ret_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (istart) begin
          len_d     = ilen;
          iss_cnt_d = '0;
          ret_cnt_d = '0;
          state_d   = iop ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (isval) begin
          wr_d      = 1'b1;
          wstart_d  = (iss_cnt_q == '0);
          wdat_d    = isdat;
          iss_cnt_d = iss_cnt_q + CNT_W'(1);
          if (iss_cnt_d == words) state_d = ST_DONE;
        end
      end
      ST_READ: begin
        rd_d      = 1'b1;
        rstart_d  = (iss_cnt_q == '0);
        iss_cnt_d = iss_cnt_q + CNT_W'(1);
        if (iss_cnt_d == words) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ret_cnt_d == words) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Control state and strobes.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      iss_cnt_q <= '0;
      ret_cnt_q <= '0;
      wr_q      <= 1'b0;
      wstart_q  <= 1'b0;
      rd_q      <= 1'b0;
      rstart_q  <= 1'b0;
      val_q     <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (iclkena) begin
      state_q   <= state_d;
      len_q     <= len_d;
      iss_cnt_q <= iss_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      wr_q      <= wr_d;
      wstart_q  <= wstart_d;
      rd_q      <= rd_d;
      rstart_q  <= rstart_d;
      val_q     <= val_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Data words carry no reset.
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      wdat_q <= wdat_d;
      dat_q  <= dat_d;
    end
  end

  assign oreg_write  = wr_q;
  assign oreg_wstart = wstart_q;
  assign oreg_wdat   = wdat_q;
  assign oreg_read   = rd_q;
  assign oreg_rstart = rstart_q;
  assign oval        = val_q;
  assign osop        = sop_q;
  assign oeop        = eop_q;
  assign odat        = dat_q;
  assign obusy       = busy_q;
  assign odone       = done_q;

endmodule
